// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro used by the top: DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    sat_inc = (v == {WAIT_CNT_W{1'b1}}) ? v : v + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of arbitration cycles the DMA port has been denied,
// and the starvation flag that forces a DMA win.
import dmem_arb_pkg::*;

module dmem_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_arb,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic starve
);

  logic [WAIT_CNT_W-1:0] wait_cnt_r;

  // Denied-cycle counter; frozen while a read is returning data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_r <= {WAIT_CNT_W{1'b0}};
    end else if (!dma_req || dma_gnt) begin
      wait_cnt_r <= {WAIT_CNT_W{1'b0}};
    end else if (in_arb) begin
      wait_cnt_r <= sat_inc(wait_cnt_r);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign starve = (wait_cnt_r >= WAIT_CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with a DMA starvation limit.
// Define DMEM_ARB_STATS_EN to add the stall/grant statistics ports.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_stall,
  output logic [15:0]       stat_dma_grants
`endif
);

  state_t state_r;
  owner_t owner_s;
  logic   starve_s;
  logic   cpu_done_s;

  dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .in_arb  (state_r == ARB),
    .dma_req (dma_req),
    .dma_gnt (dma_gnt),
    .starve  (starve_s)
  );

  // Owner selection and memory/requester muxing; everything is held low in reset.
  always_comb begin
    owner_s    = OWN_NONE;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    dma_gnt    = 1'b0;
    dma_rvalid = 1'b0;
    dma_rdata  = {DATA_W{1'b0}};
    cpu_rdata  = {DATA_W{1'b0}};
    cpu_done_s = 1'b0;
    if (rst && state_r == ARB) begin
      if (dma_req && (starve_s || !cpu_req)) begin
        owner_s = OWN_DMA;
      end else if (cpu_req) begin
        owner_s = OWN_CPU;
      end else begin
        owner_s = OWN_NONE;
      end
    end else begin
      owner_s = OWN_NONE;
    end
    case (owner_s)
      OWN_DMA: begin
        mem_en    = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_gnt   = 1'b1;
      end
      OWN_CPU: begin
        mem_en     = 1'b1;
        mem_we     = cpu_we;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        cpu_done_s = cpu_we;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
    if (rst && state_r == CPU_RD) begin
      cpu_rdata  = mem_rdata;
      cpu_done_s = 1'b1;
    end else begin
      cpu_rdata = {DATA_W{1'b0}};
    end
    if (rst && state_r == DMA_RD) begin
      dma_rdata  = mem_rdata;
      dma_rvalid = 1'b1;
    end else begin
      dma_rvalid = 1'b0;
    end
    cpu_stall = rst && cpu_req && !cpu_done_s;
  end

  // Sequencer: a granted read spends exactly one cycle in its return state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ARB;
    end else begin
      case (state_r)
        ARB: begin
          if (owner_s == OWN_DMA && !dma_we) begin
            state_r <= DMA_RD;
          end else if (owner_s == OWN_CPU && !cpu_we) begin
            state_r <= CPU_RD;
          end else begin
            state_r <= ARB;
          end
        end
        CPU_RD:  state_r <= ARB;
        DMA_RD:  state_r <= ARB;
        default: state_r <= ARB;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu_stall_r;
  logic [15:0] stat_dma_grants_r;

  // Free-running, wrapping event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cpu_stall_r  <= 16'd0;
      stat_dma_grants_r <= 16'd0;
    end else begin
      stat_cpu_stall_r  <= stat_cpu_stall_r + (cpu_stall ? 16'd1 : 16'd0);
      stat_dma_grants_r <= stat_dma_grants_r + (dma_gnt ? 16'd1 : 16'd0);
    end
  end

  assign stat_cpu_stall  = stat_cpu_stall_r;
  assign stat_dma_grants = stat_dma_grants_r;
`endif

endmodule
